fp_accumulator: RTL and testbench

Downstream stage of fp_multiplier in the floating-point MAC datapath. It takes each product word and its Exception/Overflow/Underflow flags over a valid/ready handshake, and adds the product into an internal accumulator register with a multi-cycle align/add/normalise FSM. When the last product of a dot product arrives, it presents the final sum plus sticky flags on a valid/ready output, then clears itself for the next dot product. It uses the same packed format as the multiplier: sign | exponent | mantissa, with bias 2^(EXP_WIDTH-1)-1.

---
 rtl/fp_accumulator.sv | 217 +++++++++++++++++++++
 tb/tb_fp_accumulator.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// fp_accumulator: multi-cycle align/add/normalise accumulator that sums
// fp_multiplier products and emits the dot product with sticky flags.
module fp_accumulator #(
  parameter int BIT_WIDTH  = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7,
  parameter int GUARD_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_product,
  input  logic                 in_exception,
  input  logic                 in_overflow,
  input  logic                 in_underflow,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_result,
  output logic [2:0]           out_flags
);
  localparam int SIG_W = MANT_WIDTH + GUARD_BITS + 1;
  localparam int EW    = EXP_WIDTH + 2;
  localparam int LZ_W  = $clog2(SIG_W + 1);

  localparam logic [EXP_WIDTH-1:0]  EMAX   = '1;
  localparam logic [EXP_WIDTH-1:0]  EZ     = '0;
  localparam logic [MANT_WIDTH-1:0] MZ     = '0;
  localparam logic signed [EW-1:0]  EMAX_S = $signed({2'b00, EMAX});
  localparam logic signed [EW-1:0]  ZERO_S = '0;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

  state_t                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   acc_q, acc_d;
  logic [BIT_WIDTH-1:0]   prod_q, prod_d;
  logic [2:0]             flags_q, flags_d;
  logic                   last_q, last_d;
  logic                   a_sign_q, a_sign_d;
  logic                   b_sign_q, b_sign_d;
  logic signed [EW-1:0]   a_exp_q, a_exp_d;
  logic [SIG_W-1:0]       a_sig_q, a_sig_d;
  logic [SIG_W-1:0]       b_sig_q, b_sig_d;
  logic [SIG_W:0]         sum_q, sum_d;

  function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
    lzc = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++)
      if (v[i]) lzc = LZ_W'(SIG_W - 1 - i);
  endfunction

  logic                  acc_s, prod_s;
  logic [EXP_WIDTH-1:0]  acc_e, prod_e;
  logic [MANT_WIDTH-1:0] acc_m, prod_m;

  assign acc_s  = acc_q[BIT_WIDTH-1];
  assign acc_e  = acc_q[BIT_WIDTH-2 -: EXP_WIDTH];
  assign acc_m  = acc_q[MANT_WIDTH-1:0];
  assign prod_s = prod_q[BIT_WIDTH-1];
  assign prod_e = prod_q[BIT_WIDTH-2 -: EXP_WIDTH];
  assign prod_m = prod_q[MANT_WIDTH-1:0];

  logic                 swap;
  logic [SIG_W-1:0]     acc_sig, prod_sig, big_sig, sml_sig;
  logic [EXP_WIDTH-1:0] big_e, sml_e, e_diff;

  always_comb begin
    acc_sig  = '0;
    prod_sig = '0;
    if (acc_e != EZ)
      acc_sig = {1'b1, acc_m, {GUARD_BITS{1'b0}}};
    if (prod_e != EZ)
      prod_sig = {1'b1, prod_m, {GUARD_BITS{1'b0}}};
    swap    = prod_q[BIT_WIDTH-2:0] > acc_q[BIT_WIDTH-2:0];
    big_sig = swap ? prod_sig : acc_sig;
    sml_sig = swap ? acc_sig : prod_sig;
    big_e   = swap ? prod_e : acc_e;
    sml_e   = swap ? acc_e : prod_e;
    e_diff  = big_e - sml_e;
  end

  logic [LZ_W-1:0]      lz;
  logic [SIG_W-1:0]     nsig;
  logic signed [EW-1:0] nexp;
  logic [BIT_WIDTH-1:0] norm_res;
  logic [2:0]           norm_flags;

  always_comb begin
    lz         = lzc(sum_q[SIG_W-1:0]);
    nsig       = sum_q[SIG_W-1:0];
    nexp       = a_exp_q;
    norm_res   = '0;
    norm_flags = '0;
    if (sum_q[SIG_W]) begin
      nsig = sum_q[SIG_W:1];
      nexp = a_exp_q + $signed(EW'(1));
    end else begin
      nsig = sum_q[SIG_W-1:0] << lz;
      nexp = a_exp_q - $signed(EW'(lz));
    end
    // Infinite operands override the arithmetic path entirely.
    if (acc_e == EMAX && prod_e == EMAX && acc_s != prod_s) begin
      norm_res   = {1'b0, EMAX, MZ};
      norm_flags = 3'b100;
    end else if (acc_e == EMAX) begin
      norm_res = {acc_s, EMAX, MZ};
    end else if (prod_e == EMAX) begin
      norm_res = {prod_s, EMAX, MZ};
    end else if (sum_q == '0) begin
      norm_res = '0;
    end else if (nexp >= EMAX_S) begin
      norm_res   = {a_sign_q, EMAX, MZ};
      norm_flags = 3'b010;
    end else if (nexp <= ZERO_S) begin
      norm_res   = {a_sign_q, EZ, MZ};
      norm_flags = 3'b001;
    end else begin
      norm_res = {a_sign_q, nexp[EXP_WIDTH-1:0],
                  nsig[SIG_W-2 -: MANT_WIDTH]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{nsig[SIG_W-1], nsig[GUARD_BITS-1:0]};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    flags_d  = flags_q;
    last_d   = last_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    a_exp_d  = a_exp_q;
    a_sig_d  = a_sig_q;
    b_sig_d  = b_sig_q;
    sum_d    = sum_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          acc_d   = '0;
          flags_d = '0;
        end else if (in_valid) begin
          prod_d  = in_product;
          last_d  = in_last;
          flags_d = flags_q |
                    {in_exception, in_overflow, in_underflow};
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        a_sign_d = swap ? prod_s : acc_s;
        b_sign_d = swap ? acc_s : prod_s;
        a_exp_d  = $signed({2'b00, big_e});
        a_sig_d  = big_sig;
        b_sig_d  = (int'(e_diff) >= SIG_W) ? '0 : (sml_sig >> e_diff);
        state_d  = ADD;
      end
      ADD: begin
        if (a_sign_q == b_sign_q)
          sum_d = {1'b0, a_sig_q} + {1'b0, b_sig_q};
        else
          sum_d = {1'b0, a_sig_q} - {1'b0, b_sig_q};
        state_d = NORM;
      end
      NORM: begin
        acc_d   = norm_res;
        flags_d = flags_q | norm_flags;
        state_d = last_q ? OUT : IDLE;
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          flags_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      prod_q   <= '0;
      flags_q  <= '0;
      last_q   <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      a_exp_q  <= '0;
      a_sig_q  <= '0;
      b_sig_q  <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      flags_q  <= flags_d;
      last_q   <= last_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      a_exp_q  <= a_exp_d;
      a_sig_q  <= a_sig_d;
      b_sig_q  <= b_sig_d;
      sum_q    <= sum_d;
    end
  end

  assign in_ready   = rst_n && (state_q == IDLE) && !clr;
  assign out_valid  = (state_q == OUT);
  assign out_result = out_valid ? acc_q : '0;
  assign out_flags  = out_valid ? flags_q : '0;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed and randomized dot products checked
// against an integer-significand reference of the accumulate rules.
module tb_fp_accumulator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_product;
  logic        in_exception;
  logic        in_overflow;
  logic        in_underflow;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fp_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_product   (in_product),
    .in_exception (in_exception),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of a word is sig * 2^(exp-137), sig holding 3 guard bits.
  function automatic void ref_add(input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] r,
                                  output logic [2:0] f);
    int ea, eb, ma, mb, t, d, s, e;
    logic sa, sb, ts;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    sa = a[15];
    sb = b[15];
    r = 16'h0000;
    f = 3'b000;
    if (ea == 255 && eb == 255 && sa != sb) begin
      r = 16'h7F80;
      f = 3'b100;
      return;
    end
    if (ea == 255) begin r = {sa, 8'hFF, 7'h00}; return; end
    if (eb == 255) begin r = {sb, 8'hFF, 7'h00}; return; end
    ma = (ea != 0) ? (128 + int'(a[6:0])) * 8 : 0;
    mb = (eb != 0) ? (128 + int'(b[6:0])) * 8 : 0;
    if (eb * 128 + int'(b[6:0]) > ea * 128 + int'(a[6:0])) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      ts = sa; sa = sb; sb = ts;
    end
    d = ea - eb;
    mb = (d >= 11) ? 0 : mb / (1 << d);
    s = (sa == sb) ? ma + mb : ma - mb;
    if (s == 0) return;
    e = ea;
    while (s >= 2048) begin s = s / 2; e++; end
    while (s < 1024) begin s = s * 2; e--; end
    if (e >= 255) begin
      r = {sa, 8'hFF, 7'h00};
      f = 3'b010;
    end else if (e <= 0) begin
      r = {sa, 15'h0000};
      f = 3'b001;
    end else begin
      r = {sa, 8'(e), 7'((s / 8) % 128)};
    end
  endfunction

  task automatic send(input logic [15:0] p, input logic [2:0] f,
                      input logic l, output int edge_no);
    int n = 0;
    in_product = p;
    {in_exception, in_overflow, in_underflow} = f;
    in_last = l;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready_timeout", 32'(n < 20), 1);
    @(posedge clk); #1;
    edge_no = cyc - 1;
    in_valid = 1'b0;
    in_last = 1'b0;
    {in_exception, in_overflow, in_underflow} = 3'b000;
  endtask

  task automatic recv(input string tag, input logic [15:0] er,
                      input logic [2:0] ef, input int acc_e,
                      input int stall);
    int n = 0;
    out_ready = (stall == 0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_latency"}, 32'(cyc - 1 - acc_e), 3);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_flags"}, out_flags, ef);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_result"}, out_result, er);
      chk({tag, "_hold_flags"}, out_flags, ef);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  function automatic logic [15:0] rand_prod();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) e = 8'h00;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'hFE;
    else if (k == 3) e = 8'h01;
    else e = 8'($urandom_range(115, 140));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  initial begin
    int e1, e2, n, len;
    logic [15:0] m_acc, p;
    logic [2:0] m_flags, f, of;

    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_product = '0;
    {in_exception, in_overflow, in_underflow} = 3'b000;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    send(16'h3F80, 3'b000, 1'b0, e1);
    send(16'h3F80, 3'b000, 1'b1, e2);
    chk("one_plus_one_gap", 32'(e2 - e1), 4);
    recv("one_plus_one", 16'h4000, 3'b000, e2, 0);

    send(16'h3F80, 3'b000, 1'b0, e1);
    send(16'hBF80, 3'b000, 1'b1, e2);
    recv("cancel", 16'h0000, 3'b000, e2, 0);

    send(16'h7F00, 3'b000, 1'b0, e1);
    send(16'h7F00, 3'b000, 1'b1, e2);
    recv("ovf", 16'h7F80, 3'b010, e2, 0);
    send(16'h7F00, 3'b010, 1'b0, e1);
    send(16'h7F00, 3'b000, 1'b1, e2);
    recv("ovf_in", 16'h7F80, 3'b010, e2, 0);

    send(16'h3F80, 3'b000, 1'b0, e1);
    send(16'h3580, 3'b000, 1'b1, e2);
    recv("shift_out", 16'h3F80, 3'b000, e2, 0);

    send(16'h7F80, 3'b000, 1'b0, e1);
    send(16'hFF80, 3'b000, 1'b1, e2);
    recv("inf_clash", 16'h7F80, 3'b100, e2, 0);

    send(16'h00C0, 3'b000, 1'b0, e1);
    send(16'h8080, 3'b000, 1'b1, e2);
    recv("unf", 16'h0000, 3'b001, e2, 0);

    send(16'h3F80, 3'b000, 1'b0, e1);
    send(16'h4000, 3'b000, 1'b1, e2);
    recv("stall", 16'h4040, 3'b000, e2, 5);
    send(16'h4000, 3'b000, 1'b1, e2);
    recv("after_stall", 16'h4000, 3'b000, e2, 0);

    send(16'h4000, 3'b000, 1'b0, e1);
    send(16'h3F80, 3'b000, 1'b1, e2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_result", out_result, 0);
    chk("abort_out_flags", out_flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'h3F80, 3'b000, 1'b1, e2);
    recv("post_abort", 16'h3F80, 3'b000, e2, 0);

    out_ready = 1'b0;
    send(16'h7F00, 3'b000, 1'b0, e1);
    send(16'h7F00, 3'b000, 1'b1, e2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_rst_valid_before", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("out_rst_valid", out_valid, 0);
    chk("out_rst_result", out_result, 0);
    chk("out_rst_flags", out_flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(16'h4000, 3'b000, 1'b0, e1);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_wait_ready", in_ready, 1);
    clr = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    send(16'h3F80, 3'b000, 1'b1, e2);
    recv("after_clr", 16'h3F80, 3'b000, e2, 0);

    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(1, 5);
      m_acc = 16'h0000;
      m_flags = 3'b000;
      for (int k = 0; k < len; k++) begin
        p = rand_prod();
        f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        send(p, f, k == len - 1, e2);
        ref_add(m_acc, p, m_acc, of);
        m_flags = m_flags | f | of;
      end
      recv("rand", m_acc, m_flags, e2, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
